// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: valid/ready byte input, DEPTH-entry FIFO, LSB-first serial output.
// Define UART_TX_PARITY_EN to insert one even-parity bit between the data bits and STOP.
module uart_tx_fifo #(
    parameter int CLK_HZ = 16000000,
    parameter int BAUD   = 115200,
    parameter int DEPTH  = 8
) (
    input  logic                     CLK_16mhz,
    input  logic                     RESET,
    input  logic [7:0]               DATA_IN,
    input  logic                     VALID,
    output logic                     READY,
    output logic                     TX,
    output logic                     BUSY,
    output logic [$clog2(DEPTH):0]   COUNT
);

    localparam int AW   = $clog2(DEPTH);
    localparam int CNTW = AW + 1;
    localparam int DIV  = CLK_HZ / BAUD;
    localparam int CW   = $clog2(DIV);
    localparam logic [CW-1:0]   CNT_MAX = CW'(DIV - 1);
    localparam logic [CNTW-1:0] FULL    = CNTW'(DEPTH);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    logic [7:0]      mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CNTW-1:0] count;
    state_t          state;
    logic [CW-1:0]   cnt;
    logic [2:0]      bit_idx;
    logic [7:0]      shift;
`ifdef UART_TX_PARITY_EN
    logic            par;
`endif
    logic            push;
    logic            pop;
    logic            bit_end;

    always_comb begin
        READY   = (count != FULL) && !RESET;
        push    = VALID && (count != FULL) && !RESET;
        bit_end = (cnt == CNT_MAX);
        // Pop happens only when the line is free: from IDLE, or at the end of STOP.
        pop     = (count != '0) && ((state == IDLE) || ((state == STOP) && bit_end));
    end

    assign COUNT = count;

    always_ff @(posedge CLK_16mhz) begin
        if (push)
            mem[wr_ptr] <= DATA_IN;
    end

    always_ff @(posedge CLK_16mhz or posedge RESET) begin
        if (RESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            unique case ({push, pop})
                2'b10:   count <= count + CNTW'(1);
                2'b01:   count <= count - CNTW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge CLK_16mhz or posedge RESET) begin
        if (RESET) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shift   <= '0;
            TX      <= 1'b1;
            BUSY    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par     <= 1'b0;
`endif
        end else if (pop) begin
            shift   <= mem[rd_ptr];
`ifdef UART_TX_PARITY_EN
            par     <= ^mem[rd_ptr];
`endif
            state   <= START;
            TX      <= 1'b0;
            BUSY    <= 1'b1;
            cnt     <= '0;
            bit_idx <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    cnt <= '0;
                end
                START: begin
                    cnt <= bit_end ? '0 : cnt + CW'(1);
                    if (bit_end) begin
                        state <= DATA;
                        TX    <= shift[0];
                    end
                end
                DATA: begin
                    cnt <= bit_end ? '0 : cnt + CW'(1);
                    if (bit_end) begin
                        if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            state <= PARITY;
                            TX    <= par;
`else
                            state <= STOP;
                            TX    <= 1'b1;
`endif
                        end else begin
                            shift   <= shift >> 1;
                            TX      <= shift[1];
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    cnt <= bit_end ? '0 : cnt + CW'(1);
                    if (bit_end) begin
                        state <= STOP;
                        TX    <= 1'b1;
                    end
                end
`endif
                STOP: begin
                    cnt <= bit_end ? '0 : cnt + CW'(1);
                    if (bit_end) begin
                        state <= IDLE;
                        BUSY  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    TX    <= 1'b1;
                    BUSY  <= 1'b0;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomized self-checking bench for uart_tx_fifo against a frame-level queue model.
// Honours UART_TX_PARITY_EN the same way as the design.
`timescale 1ns/1ps
module tb_uart_tx_fifo;

    localparam int CLK_HZ = 16000000;
    localparam int BAUD   = 115200;
    localparam int DEPTH  = 8;
    localparam int DIV    = CLK_HZ / BAUD;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME  = 11 * DIV;
`else
    localparam int FRAME  = 10 * DIV;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       valid;
    logic [7:0] din;
    logic       ready;
    logic       tx;
    logic       busy;
    logic [3:0] count;

    uart_tx_fifo #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .DEPTH(DEPTH)) dut (
        .CLK_16mhz (clk),
        .RESET     (rst),
        .DATA_IN   (din),
        .VALID     (valid),
        .READY     (ready),
        .TX        (tx),
        .BUSY      (busy),
        .COUNT     (count)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int unsigned busy_cycles;
    string       phase = "reset";

    // Reference model: bytes waiting, plus position k (cycles) inside the frame on the line.
    logic [7:0]  q[$];
    bit          in_frame = 1'b0;
    int unsigned k = 0;
    logic [7:0]  cur = '0;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s.%s: got %0d expected %0d at %0t", phase, tag, got, exp, $time);
    endtask

    function automatic logic exp_tx();
        int unsigned b;
        if (!in_frame) return 1'b1;
        b = k / DIV;
        if (b == 0) return 1'b0;
        if (b <= 8) return cur[b-1];
`ifdef UART_TX_PARITY_EN
        if (b == 9) return ^cur;
`endif
        return 1'b1;
    endfunction

    task automatic model_clear();
        q.delete();
        in_frame = 1'b0;
        k = 0;
    endtask

    task automatic model_edge();
        int unsigned pre = q.size();
        bit do_push = valid && (pre != DEPTH);
        if (in_frame) begin
            k++;
            if (k == FRAME) begin
                if (pre != 0) begin
                    cur = q.pop_front();
                    k = 0;
                end else begin
                    in_frame = 1'b0;
                end
            end
        end else if (pre != 0) begin
            cur = q.pop_front();
            in_frame = 1'b1;
            k = 0;
        end
        if (do_push) q.push_back(din);
    endtask

    task automatic check_outputs();
        check("tx", tx, exp_tx());
        check("busy", busy, in_frame);
        check("count", count, q.size());
        check("ready", ready, (!rst && q.size() != DEPTH) ? 1 : 0);
    endtask

    task automatic step(input logic v, input logic [7:0] d);
        valid = v;
        din   = d;
        @(posedge clk);
        if (rst) model_clear();
        else model_edge();
        #1;
        if (busy) busy_cycles++;
        check_outputs();
    endtask

    task automatic drain();
        for (int i = 0; i < (DEPTH + 2) * FRAME; i++) begin
            if (!in_frame && q.size() == 0) break;
            step(1'b0, 8'h00);
        end
        for (int i = 0; i < 5; i++) step(1'b0, 8'h00);
        check("drained_busy", busy, 0);
        check("drained_tx", tx, 1);
    endtask

`ifdef UART_TX_PARITY_EN
    int unsigned pat55 [11] = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 0, 1};
`else
    int unsigned pat55 [10] = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1};
`endif

    initial begin
        rst = 1'b1;
        valid = 1'b0;
        din = 8'h00;
        busy_cycles = 0;
        for (int i = 0; i < 3; i++) step(1'b1, 8'hEE);
        check("rst_ready", ready, 0);
        check("rst_tx", tx, 1);
        #3 rst = 1'b0;
        #1 check("ready_after_release", ready, 1);
        for (int i = 0; i < 4; i++) step(1'b0, 8'h00);

        phase = "single";
        busy_cycles = 0;
        step(1'b1, 8'h55);
        check("count_after_push", count, 1);
        step(1'b0, 8'h00);
        check("popped_count", count, 0);
        check("start_tx", tx, 0);
        for (int i = 0; i < FRAME + 20; i++) begin
            if (in_frame && (k % DIV) == DIV / 2) check("bit", tx, pat55[k / DIV]);
            step(1'b0, 8'h00);
        end
        check("busy_len", busy_cycles, FRAME);

`ifdef UART_TX_PARITY_EN
        phase = "parity";
        busy_cycles = 0;
        step(1'b1, 8'h07);
        for (int i = 0; i < 2 * FRAME && !(in_frame && k == 9 * DIV + DIV / 2); i++) step(1'b0, 8'h00);
        check("parity_bit", tx, 1);
        drain();
        check("busy_len", busy_cycles, 1518);
`endif

        phase = "b2b";
        busy_cycles = 0;
        step(1'b1, 8'hA3);
        step(1'b1, 8'h0F);
        for (int i = 0; i < 10; i++) step(1'b0, 8'h00);
        check("count_mid", count, 1);
        for (int i = 0; i < FRAME; i++) step(1'b0, 8'h00);
        check("count_after_second_pop", count, 0);
        drain();
        check("busy_len", busy_cycles, 2 * FRAME);

        phase = "full";
        for (int i = 0; i < 12; i++) begin
            step(1'b1, 8'($urandom));
            if (i == 8) begin
                check("count_full", count, 8);
                check("ready_full", ready, 0);
            end
        end
        check("count_hold", count, 8);
        drain();

        phase = "same_edge";
        for (int i = 0; i < 4; i++) step(1'b1, 8'($urandom));
        for (int i = 0; i < 2 * FRAME && !(in_frame && k == FRAME - 1); i++) step(1'b0, 8'h00);
        check("count_pre", count, 3);
        step(1'b1, 8'hC4);
        check("count_same", count, 3);
        check("next_start", tx, 0);
        drain();

        phase = "reset_mid";
        for (int i = 0; i < 5; i++) step(1'b1, 8'($urandom));
        for (int i = 0; i < 2 * FRAME && !(in_frame && k == 4 * DIV + DIV / 2); i++) step(1'b0, 8'h00);
        check("count_pre", count, 4);
        check("tx_busy_pre", busy, 1);
        #2 rst = 1'b1;
        #1;
        check("tx_async", tx, 1);
        check("count_async", count, 0);
        check("ready_async", ready, 0);
        check("busy_async", busy, 0);
        model_clear();
        for (int i = 0; i < 3; i++) step(1'b1, 8'h99);
        #3 rst = 1'b0;
        for (int i = 0; i < 300; i++) step(1'b0, 8'h00);
        check("idle_after", tx, 1);
        step(1'b1, 8'h3C);
        drain();

        phase = "random";
        for (int i = 0; i < 6000; i++)
            step(($urandom_range(0, 99) < 3) ? 1'b1 : 1'b0, 8'($urandom));
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Buffered 8N1 UART transmitter for the TinyFPGA BX top level. It accepts bytes from fabric logic through a valid/ready handshake, queues them in a small FIFO, and serialises them LSB-first onto a single output. That output is wired to one of the board's general-purpose pins (default PIN_1) in place of the `1'bz` tie-off. The block runs entirely in the 16 MHz board clock domain.

## Interface
- `CLK_HZ`, 16000000: input clock frequency in Hz.
- `BAUD`, 115200: line rate; bit period `DIV = CLK_HZ / BAUD`, truncated (138 at defaults). `DIV` must be at least 2.
- `DEPTH`, 8: FIFO entries; power of two, at least 2.
- `CLK_16mhz`, in, 1: board clock; all logic on its rising edge.
- `RESET`, in, 1: asynchronous reset, active-high.
- `DATA_IN`, in, 8: byte to queue.
- `VALID`, in, 1: `DATA_IN` is valid this cycle.
- `READY`, out, 1: FIFO can accept a byte; a push occurs on an edge where `VALID && READY`.
- `TX`, out, 1: serial line, idle high, registered.
- `BUSY`, out, 1: high whenever the FSM is not in IDLE.
- `COUNT`, out, `$clog2(DEPTH)+1`: FIFO occupancy, registered.

## Operation
- **FIFO:** circular buffer with write and read pointers of `$clog2(DEPTH)` bits; they wrap naturally. `COUNT` tracks occupancy.
- **READY:** equals `COUNT != DEPTH`, and is forced to 0 while `RESET` is high.
- **Simultaneous push and pop:** `COUNT` is unchanged and both pointers advance.
- **No push when full:** `READY` is low, so no push is accepted when full, even on an edge that also pops.
- **FSM states:** IDLE, START, DATA, PARITY (only with the macro), STOP.
- **IDLE:** if `COUNT != 0`, pop the head into the 8-bit shift register, set `TX` to 0, and go to START.
- **START:** hold for `DIV` cycles, then go to DATA; `TX` takes shift register bit 0.
- **DATA:** each bit is held `DIV` cycles, then the register shifts right. After the 8th bit go to PARITY or STOP; `TX` goes to 1 for STOP.
- **STOP:** hold `TX` = 1 for `DIV` cycles. At the end:
  - if `COUNT != 0`, pop and enter START directly (no idle gap; `TX` goes 0 on the same edge);
  - otherwise go to IDLE.
- **Counters:** bit-period counter is `$clog2(DIV)` bits and counts 0..DIV-1. Bit index counter is 3 bits.
- **Reset values:**
  - `TX` = 1, `BUSY` = 0, `COUNT` = 0, `READY` = 0 during reset and 1 after release;
  - state = IDLE, pointers = 0, counters = 0.
- **Reset mid-frame:** `TX` returns high asynchronously and queued bytes are discarded. No partial frame resumes after release.

## Timing
- **Push into an empty FIFO while IDLE:** byte accepted at edge E; `COUNT` = 1 after E. At E+1 it is popped, `TX` falls, `BUSY` rises, and `COUNT` returns to 0.
- **Frame length:** `10*DIV` cycles without parity, `11*DIV` with parity.
- **Back-to-back frames:** a STOP bit is followed immediately by the next START bit; the line is never idle between queued bytes.
- **BUSY:** falls on the edge the FSM re-enters IDLE, which is `10*DIV` edges after the start edge when no byte is queued.
- **Throughput:** one byte per frame time. Pushes are single-cycle whenever `READY` is high.

## Configuration
- `UART_TX_PARITY_EN`
  - Defined: the PARITY state is compiled in. One even-parity bit (XOR of the 8 data bits) is inserted between the data bits and STOP, lasting `DIV` cycles; frame length is `11*DIV`.
  - Undefined: the PARITY state and its logic are absent; frames are 8N1 at `10*DIV`.

## Test plan
- **Single byte:** push 0x55 at defaults -> `TX` low for 138 cycles, then 1,0,1,0,1,0,1,0 for 138 cycles each, then high. `BUSY` is high for exactly 1380 cycles.
- **Back-to-back:** push 0xA3 and 0x0F on consecutive cycles -> two contiguous frames with no idle gap, 2760 cycles total. `COUNT` reads 1 during the first frame and 0 after the second pop.
- **Full FIFO:** hold `VALID` for 12 consecutive cycles while IDLE with the FIFO empty -> 9 bytes accepted (1 popped, 8 queued). `READY` falls when `COUNT` = 8, the remaining pushes are rejected, and all 9 bytes are transmitted in order.
- **Push and pop on the same edge:** push on the STOP-end edge with `COUNT` = 3 -> `COUNT` stays 3, and the next frame carries the oldest byte.
- **Reset mid-frame:** assert `RESET` during data bit 3 with `COUNT` = 4 -> `TX` = 1 and `COUNT` = 0 immediately. After release the line stays idle until a new push.
- **Parity (`UART_TX_PARITY_EN` defined):** push 0x07 -> parity bit = 1 after the data bits, and the frame lasts 1518 cycles.
